// File: rtl/request_unit.sv
// Memory request sequencer for the single-cycle core: registers data-memory
// requests, stalls the PC until the access completes, latches a sticky halt.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | fetching; non-memory instructions retire on ihit
// DATA_WAIT | data request outstanding, PC frozen until dhit
// HALTED    | HALT retired; no requests until reset
module request_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DATA_WAIT = 2'd1;
  localparam logic [1:0] HALTED    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic       is_idle;
  logic       is_wait;
  logic       halt_take;
  logic       mem_take;
  logic       instr_inc;
  logic       stall_inc;

  assign is_idle   = (state == IDLE);
  assign is_wait   = (state == DATA_WAIT);
  assign halt_take = is_idle & ihit & cu_halt;
  assign mem_take  = is_idle & ihit & !cu_halt & (cu_dREN | cu_dWEN);

  assign imemREN = is_idle;

  always_comb begin
    pc_en = 1'b0;
    if (nRST) begin
      if (is_idle)
        pc_en = ihit & !cu_dREN & !cu_dWEN & !cu_halt;
      else if (is_wait)
        pc_en = dhit;
    end
  end

  // HALT retires without raising pc_en, so it is counted separately
  assign instr_inc = pc_en | halt_take;
  assign stall_inc = (is_idle & !ihit) | (is_wait & !dhit);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      dmemREN <= 1'b0;
      dmemWEN <= 1'b0;
      halt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt_take) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (mem_take) begin
            state   <= DATA_WAIT;
            dmemWEN <= cu_dWEN;
            dmemREN <= cu_dREN & !cu_dWEN;
          end
        end
        DATA_WAIT: begin
          if (dhit) begin
            state   <= IDLE;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
          end
        end
        HALTED: begin
          dmemREN <= 1'b0;
          dmemWEN <= 1'b0;
          halt    <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          dmemREN <= 1'b0;
          dmemWEN <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (instr_inc && instr_count != CNT_MAX)
        instr_count <= instr_count + 1'b1;
      if (stall_inc && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit; a second 3-bit-counter instance shares
// the stimulus so counter saturation can be observed.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, cu_dREN, cu_dWEN, cu_halt;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt;
  logic [31:0] instr_count, stall_count;
  logic        imemREN_s, dmemREN_s, dmemWEN_s, pc_en_s, halt_s;
  logic [2:0]  instr_count_s, stall_count_s;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  request_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  request_unit #(.CNT_W(3)) dut_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .imemREN(imemREN_s), .dmemREN(dmemREN_s), .dmemWEN(dmemWEN_s),
    .pc_en(pc_en_s), .halt(halt_s),
    .instr_count(instr_count_s), .stall_count(stall_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 ns after the rising edge; checks happen mid-cycle
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b1;
    cu_dREN = 1'b0; cu_dWEN = 1'b0; cu_halt = 1'b0;
    settle();
    check("rst_pc_en_pre", pc_en, 0);

    tick();
    check("rst_imemREN", imemREN, 1);
    check("rst_dmemREN", dmemREN, 0);
    check("rst_dmemWEN", dmemWEN, 0);
    check("rst_halt", halt, 0);
    check("rst_instr", instr_count, 0);
    check("rst_stall", stall_count, 0);
    check("rst_pc_en", pc_en, 0);
    tick();
    nRST = 1'b1; dhit = 1'b0;

    // three ALU instructions back to back
    for (int i = 0; i < 3; i++) begin
      settle();
      check("alu_pc_en", pc_en, 1);
      check("alu_dmem", {dmemREN, dmemWEN}, 0);
      tick();
    end
    ihit = 1'b0;
    settle();
    check("alu_instr", instr_count, 3);
    check("alu_stall", stall_count, 0);

    // LW with dhit arriving after three wait cycles
    ihit = 1'b1; cu_dREN = 1'b1;
    settle();
    check("lw_issue_pc_en", pc_en, 0);
    check("lw_issue_dmemREN", dmemREN, 0);
    tick();
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lw_wait_dmemREN", dmemREN, 1);
      check("lw_wait_pc_en", pc_en, 0);
      check("lw_wait_imemREN", imemREN, 0);
      tick();
    end
    dhit = 1'b1;
    settle();
    check("lw_hit_dmemREN", dmemREN, 1);
    check("lw_hit_pc_en", pc_en, 1);
    tick();
    dhit = 1'b0; cu_dREN = 1'b0;
    settle();
    check("lw_done_dmemREN", dmemREN, 0);
    check("lw_done_imemREN", imemREN, 1);
    check("lw_instr", instr_count, 4);
    check("lw_stall", stall_count, 3);

    // SW with illegal dREN+dWEN encoding: write wins
    ihit = 1'b1; cu_dREN = 1'b1; cu_dWEN = 1'b1;
    settle();
    check("sw_issue_pc_en", pc_en, 0);
    tick();
    ihit = 1'b0; dhit = 1'b1;
    settle();
    check("sw_dmemWEN", dmemWEN, 1);
    check("sw_dmemREN", dmemREN, 0);
    check("sw_pc_en", pc_en, 1);
    tick();
    dhit = 1'b0; cu_dREN = 1'b0; cu_dWEN = 1'b0;
    settle();
    check("sw_done_imemREN", imemREN, 1);
    check("sw_done_dmem", {dmemREN, dmemWEN}, 0);
    check("sw_instr", instr_count, 5);
    check("sw_stall", stall_count, 3);

    // HALT beats a simultaneous store
    ihit = 1'b1; cu_halt = 1'b1; cu_dWEN = 1'b1;
    settle();
    check("halt_issue_pc_en", pc_en, 0);
    check("halt_issue_halt", halt, 0);
    tick();
    ihit = 1'b0; cu_halt = 1'b0; cu_dWEN = 1'b0;
    settle();
    check("halt_halt", halt, 1);
    check("halt_dmemWEN", dmemWEN, 0);
    check("halt_imemREN", imemREN, 0);
    check("halt_instr", instr_count, 6);
    for (int i = 0; i < 4; i++) begin
      ihit = i[0]; dhit = ~i[0]; cu_dREN = 1'b1;
      settle();
      check("halted_pc_en", pc_en, 0);
      check("halted_imemREN", imemREN, 0);
      tick();
    end
    ihit = 1'b0; dhit = 1'b0; cu_dREN = 1'b0;
    settle();
    check("halted_halt", halt, 1);
    check("halted_dmem", {dmemREN, dmemWEN}, 0);
    check("halted_instr", instr_count, 6);
    check("halted_stall", stall_count, 3);

    // saturation: ten ALU instructions into a 3-bit counter
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    settle();
    check("sat_rst_halt", halt, 0);
    check("sat_rst_instr", instr_count, 0);
    ihit = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    ihit = 1'b0;
    settle();
    check("sat_instr_wide", instr_count, 10);
    check("sat_instr_3b", {29'd0, instr_count_s}, 7);
    for (int i = 0; i < 9; i++) tick();
    check("sat_stall_3b", {29'd0, stall_count_s}, 7);
    check("sat_stall_wide", stall_count, 9);

    // reset in the middle of a load
    ihit = 1'b1; cu_dREN = 1'b1;
    tick();
    ihit = 1'b0;
    settle();
    check("abort_dmemREN_pre", dmemREN, 1);
    nRST = 1'b0; dhit = 1'b1;
    settle();
    check("abort_pc_en_rst", pc_en, 0);
    tick();
    nRST = 1'b1; dhit = 1'b0; cu_dREN = 1'b0;
    settle();
    check("abort_dmemREN", dmemREN, 0);
    check("abort_imemREN", imemREN, 1);
    check("abort_instr", instr_count, 0);
    check("abort_stall", stall_count, 0);
    check("abort_pc_en", pc_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
